// File: rtl/calc_seq_alu.sv
// rtl/calc_seq_alu.sv - clocked calculator ALU with iterative MUL/DIV/MAC
module calc_seq_alu #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               clr,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               err,
    output logic               ovf
);
    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_MAC = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;
    // Shift-add multiplier state: accumulator, left-shifting multiplicand, right-shifting multiplier
    logic [RW-1:0]    r_acc;
    logic [RW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    // Restoring divider state: partial remainder and dividend/quotient shift register
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [RW-1:0]    r_result;
    logic             r_err;
    logic             r_ovf;

    logic             w_iter;
    logic [RW-1:0]    w_mul_nxt;
    logic [WIDTH:0]   w_div_shift;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [RW:0]      w_mac_sum;
    logic [WIDTH:0]   w_diff;
    logic [RW-1:0]    w_final;

    assign w_iter      = (op == OP_MUL) || (op == OP_DIV) || (op == OP_MAC);
    assign w_mul_nxt   = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_div_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_div_ge    = w_div_shift >= {1'b0, r_b};
    assign w_rem_nxt   = w_div_ge ? WIDTH'(w_div_shift - {1'b0, r_b}) : w_div_shift[WIDTH-1:0];
    assign w_quo_nxt   = {r_quo[WIDTH-2:0], w_div_ge};
    // MAC adds onto whatever result currently holds; bit RW is the wrap indicator
    assign w_mac_sum   = {1'b0, r_result} + {1'b0, w_mul_nxt};
    // Bit WIDTH of the widened difference is the borrow
    assign w_diff      = {1'b0, r_a} - {1'b0, r_b};

    // Final value written to result on the last RUN cycle
    always_comb begin
        w_final = '0;
        case (r_op)
            OP_ADD:  w_final = RW'(r_a) + RW'(r_b);
            OP_SUB:  w_final = RW'(w_diff);
            OP_MUL:  w_final = w_mul_nxt;
            OP_DIV:  w_final = {w_rem_nxt, w_quo_nxt};
            OP_AND:  w_final = RW'(r_a & r_b);
            OP_OR:   w_final = RW'(r_a | r_b);
            OP_XOR:  w_final = RW'(r_a ^ r_b);
            default: w_final = w_mac_sum[RW-1:0];
        endcase
    end

    // Next-state and status outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != S_IDLE);
        done        = (r_state == S_DONE);
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == CW'(1)) w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Operand latch, iteration datapath and result/flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op     <= op;
                        r_a      <= a;
                        r_b      <= b;
                        r_err    <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_cnt    <= w_iter ? CW'(WIDTH) : CW'(1);
                        r_acc    <= '0;
                        r_mcand  <= RW'(a);
                        r_mplier <= b;
                        r_rem    <= '0;
                        r_quo    <= a;
                    end else if (clr) begin
                        r_result <= '0;
                        r_err    <= 1'b0;
                        r_ovf    <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_cnt    <= r_cnt - CW'(1);
                    r_acc    <= w_mul_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_rem    <= w_rem_nxt;
                    r_quo    <= w_quo_nxt;
                    if (r_cnt == CW'(1)) begin
                        r_result <= w_final;
                        r_err    <= (r_op == OP_DIV) && (r_b == '0);
                        r_ovf    <= (r_op == OP_MAC) && w_mac_sum[RW];
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign err    = r_err;
    assign ovf    = r_ovf;
endmodule

// File: tb/tb_calc_seq_alu.sv
// tb/tb_calc_seq_alu.sv - self-checking bench for calc_seq_alu (WIDTH=4 and WIDTH=8)
module tb_calc_seq_alu;
    logic       clk = 1'b0;
    logic       rst_n;

    logic       start, clr;
    logic [2:0] op;
    logic [3:0] a, b;
    logic       busy, done, err, ovf;
    logic [7:0] result;

    logic        start8, clr8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, err8, ovf8;
    logic [15:0] result8;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_result, m8_result;
    bit          m_err, m_ovf, m8_err, m8_ovf;

    typedef struct {
        bit         is_clr;
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp_result;
        bit         exp_err;
        bit         exp_ovf;
    } vec_t;

    vec_t vecs[$];

    calc_seq_alu #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .err(err), .ovf(ovf)
    );

    calc_seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .clr(clr8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .err(err8), .ovf(ovf8)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: the operation's arithmetic meaning for a w-bit datapath
    function automatic logic [31:0] ref_calc(input int w, input int opc, input int x, input int y,
                                             input int prev, output bit e, output bit v);
        longint mask, full, s;
        mask = (64'd1 << w) - 1;
        full = (64'd1 << (2 * w)) - 1;
        e = 0;
        v = 0;
        case (opc)
            0: s = x + y;
            1: s = ((x - y) & mask) | ((x < y) ? (mask + 1) : 0);
            2: s = longint'(x) * y;
            3: begin
                if (y == 0) begin
                    e = 1;
                    s = (longint'(x) << w) | mask;
                end else begin
                    s = (longint'(x % y) << w) | (x / y);
                end
            end
            4: s = x & y;
            5: s = x | y;
            6: s = x ^ y;
            default: begin
                s = longint'(prev) + longint'(x) * y;
                v = s > full;
                s = s & full;
            end
        endcase
        return 32'(s);
    endfunction

    function automatic int exp_latency(input int w, input logic [2:0] o);
        return (o == 3'd2 || o == 3'd3 || o == 3'd7) ? w : 1;
    endfunction

    // One WIDTH=4 operation; ign_at>=0 pulses a conflicting start during RUN at that cycle
    task automatic run4(input logic [2:0] op_i, input logic [3:0] a_i, input logic [3:0] b_i,
                        input bit with_clr, input int ign_at, input string nm);
        int lat;
        bit e, v;
        logic [31:0] exp_r;
        @(negedge clk);
        op = op_i; a = a_i; b = b_i; start = 1'b1; clr = with_clr;
        @(posedge clk); #1;
        start = 1'b0; clr = 1'b0;
        op = 3'($urandom); a = 4'($urandom); b = 4'($urandom);
        check({nm, " busy"}, 32'(busy), 1);
        exp_r = ref_calc(4, int'(op_i), int'(a_i), int'(b_i), int'(m_result), e, v);
        lat = 0;
        while (!done && lat < 40) begin
            if (lat == ign_at) begin
                start = 1'b1; op = 3'd0; a = 4'd1; b = 4'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check({nm, " latency"}, lat, exp_latency(4, op_i));
        check({nm, " result"}, 32'(result), exp_r);
        check({nm, " err"}, 32'(err), 32'(e));
        check({nm, " ovf"}, 32'(ovf), 32'(v));
        m_result = exp_r; m_err = e; m_ovf = v;
        @(posedge clk); #1;
        check({nm, " back idle"}, {30'd0, busy, done}, 0);
    endtask

    task automatic clr4(input string nm);
        @(negedge clk);
        clr = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        clr = 1'b0;
        m_result = 0; m_err = 0; m_ovf = 0;
        check({nm, " result"}, 32'(result), 0);
        check({nm, " flags"}, {30'd0, err, ovf}, 0);
    endtask

    task automatic run8(input logic [2:0] op_i, input logic [7:0] a_i, input logic [7:0] b_i,
                        input string nm);
        int lat;
        bit e, v;
        logic [31:0] exp_r;
        @(negedge clk);
        op8 = op_i; a8 = a_i; b8 = b_i; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        exp_r = ref_calc(8, int'(op_i), int'(a_i), int'(b_i), int'(m8_result), e, v);
        lat = 0;
        while (!done8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, " latency"}, lat, exp_latency(8, op_i));
        check({nm, " result"}, 32'(result8), exp_r);
        check({nm, " flags"}, {30'd0, err8, ovf8}, {30'd0, e, v});
        m8_result = exp_r; m8_err = e; m8_ovf = v;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 0; clr = 0; op = 0; a = 0; b = 0;
        start8 = 0; clr8 = 0; op8 = 0; a8 = 0; b8 = 0;
        m_result = 0; m_err = 0; m_ovf = 0;
        m8_result = 0; m8_err = 0; m8_ovf = 0;

        vecs.push_back('{0, 3'd0, 4'd9,  4'd8,  8'h11, 0, 0});
        vecs.push_back('{0, 3'd1, 4'd3,  4'd5,  8'h1E, 0, 0});
        vecs.push_back('{0, 3'd2, 4'd15, 4'd15, 8'hE1, 0, 0});
        vecs.push_back('{0, 3'd3, 4'd13, 4'd4,  8'h13, 0, 0});
        vecs.push_back('{0, 3'd3, 4'd7,  4'd0,  8'h7F, 1, 0});
        vecs.push_back('{0, 3'd0, 4'd1,  4'd1,  8'h02, 0, 0});
        vecs.push_back('{1, 3'd0, 4'd0,  4'd0,  8'h00, 0, 0});
        vecs.push_back('{0, 3'd7, 4'd15, 4'd15, 8'hE1, 0, 0});
        vecs.push_back('{0, 3'd7, 4'd15, 4'd15, 8'hC2, 0, 1});
        vecs.push_back('{0, 3'd7, 4'd15, 4'd15, 8'hA3, 0, 1});
        vecs.push_back('{1, 3'd0, 4'd0,  4'd0,  8'h00, 0, 0});

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset result", 32'(result), 0);
        check("reset err", 32'(err), 0);
        check("reset ovf", 32'(ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].is_clr) clr4($sformatf("vec%0d clr", i));
            else run4(vecs[i].op, vecs[i].a, vecs[i].b, 0, -1, $sformatf("vec%0d", i));
            check($sformatf("vec%0d table result", i), 32'(result), 32'(vecs[i].exp_result));
            check($sformatf("vec%0d table err", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d table ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
        end

        // Start pulsed while RUN is ignored and not queued
        run4(3'd2, 4'd15, 4'd15, 0, 1, "mul ignore");
        check("mul ignore const", 32'(result), 32'h0E1);
        repeat (3) begin
            @(posedge clk); #1;
            check("no queued op", {30'd0, busy, done}, 0);
        end

        // Divide by zero first so err is set before the aborted op
        run4(3'd3, 4'd9, 4'd0, 0, -1, "div0 pre");
        @(negedge clk);
        op = 3'd2; a = 4'd15; b = 4'd15; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check("async rst busy", 32'(busy), 0);
        check("async rst done", 32'(done), 0);
        check("async rst result", 32'(result), 0);
        check("async rst flags", {30'd0, err, ovf}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_result = 0; m_err = 0; m_ovf = 0;
        m8_result = 0; m8_err = 0; m8_ovf = 0;
        run4(3'd0, 4'd2, 4'd3, 0, -1, "add after rst");
        check("add after rst const", 32'(result), 32'h05);

        // start beats clr in the same IDLE cycle
        run4(3'd6, 4'hA, 4'h6, 1, -1, "xor with clr");
        check("xor with clr const", 32'(result), 32'h0C);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) clr4($sformatf("rnd%0d clr", i));
            else run4(3'($urandom), 4'($urandom), 4'($urandom), 0, -1, $sformatf("rnd%0d", i));
        end

        run8(3'd2, 8'd255, 8'd255, "w8 mul");
        check("w8 mul const", 32'(result8), 32'hFE01);
        run8(3'd3, 8'd200, 8'd7, "w8 div");
        run8(3'd7, 8'd200, 8'd250, "w8 mac");
        for (int i = 0; i < 10; i++) begin
            run8(3'($urandom), 8'($urandom), 8'($urandom), $sformatf("w8 rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/calc_seq_alu.md
Name: calc_seq_alu

Overview:
- Parametrised, clocked successor to the combinational calculator datapath.
- Latches two WIDTH-bit operands and a 3-bit opcode on a start strobe, then executes the operation.
- Simple ops take one cycle; MUL, DIV and MAC are iterative and take WIDTH cycles.
- Holds a 2*WIDTH-bit result register that doubles as the MAC accumulator; sits between the pin-level top and the operand/opcode decode.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..16; result width is 2*WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low; one clock domain only.
- start  input  1  request strobe; sampled only in IDLE.
- clr  input  1  synchronous clear of result/ovf/err; honoured only in IDLE, lower priority than start.
- op  input  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 MAC.
- a  input  WIDTH  operand A (unsigned).
- b  input  WIDTH  operand B (unsigned).
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; result is valid and stable from this cycle onward.
- result  output  2*WIDTH  registered result; holds until the next completion or clr.
- err  output  1  divide-by-zero flag.
- ovf  output  1  MAC wrap flag.

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert): state=IDLE; busy=0, done=0, result=0, err=0, ovf=0; iteration counter=0. Reset mid-operation aborts it; no partial result is kept.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on start=1 at the clock edge. At that edge: latch a, b, op; clear err and ovf; load counter with 1 for ops 000/001/100/101/110, or WIDTH for 010/011/111.
- RUN: counter decrements each cycle. At counter==1 the final result is written to result and state goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency from start edge to done high: 1 cycle for simple ops, WIDTH cycles for MUL/DIV/MAC. Minimum issue interval: 3 cycles for simple ops, WIDTH+2 for iterative ops.
- start while busy (RUN or DONE) is ignored and not queued. Operands and op may change freely after the start edge.
- clr in IDLE with start=0: result=0, err=0, ovf=0 at the next edge. If start=1 the same cycle, start wins and clr is ignored.
- ADD: result = zero-extended a+b; carry lands in bit WIDTH; upper bits 0.
- SUB: low WIDTH bits = (a-b) mod 2^WIDTH; bit WIDTH = borrow (1 iff a<b); upper bits 0.
- AND/OR/XOR: bitwise in low WIDTH bits; upper bits 0.
- MUL: shift-add, one partial product per RUN cycle, LSB of b first; full 2*WIDTH unsigned product.
- DIV: restoring, one quotient bit per cycle, MSB first. Quotient goes to low WIDTH bits, remainder to high WIDTH bits.
- DIV with b==0: runs the full WIDTH cycles; quotient = all ones, remainder = a; err=1 from the DONE cycle until the next accepted start or clr.
- MAC: result = (result_prev + a*b) mod 2^(2*WIDTH), where result_prev is the value of result at the start edge. ovf=1 if the addition wrapped.
- result_prev for MAC is whatever the last operation of any kind left in result.
- result is never written outside the RUN->DONE transition, clr, or reset; intermediate MUL/DIV partials live in internal registers.

Test Plan:
- WIDTH=4. ADD a=9 b=8, pulse start -> done one cycle after the start edge, result=0x11, busy high 2 cycles. Then SUB a=3 b=5 -> result=0x1E (low nibble 0xE, borrow bit 4 = 1).
- MUL a=15 b=15 -> done exactly 4 cycles after the start edge, result=0xE1, err=0, ovf=0. Pulse start with a=1 b=1 during RUN -> ignored, result still 0xE1.
- DIV a=13 b=4 -> result=0x13 (rem 1, quot 3), err=0. Then DIV a=7 b=0 -> result=0x7F, err=1. Then ADD 1+1 -> err clears at the start edge, result=0x02.
- clr, then MAC a=15 b=15 three times -> result 0xE1 (ovf=0), 0xC2 (ovf=1), 0xA3 (ovf=1). Then clr -> result=0, ovf=0.
- Start MUL a=15 b=15, assert rst_n=0 asynchronously in the 2nd RUN cycle -> busy, done, result, err, ovf all 0 immediately. After release, ADD 2+3 -> result=0x05 on schedule.
- start and clr high together in IDLE with op=XOR a=0xA b=0x6 -> XOR executes, result=0x0C, no clear. WIDTH=8 regression: MUL 255*255 -> result=0xFE01 after 8 cycles.
